// File: rtl/pipe_stage_skid_reg.sv
// Fetch/decode boundary register with a 2-entry skid buffer, valid/ready handshake and flush.
// Optional saturating stall/flush counters when PSR_PERF_CNT_EN is defined.
module pipe_stage_skid_reg #(
  parameter int unsigned         PC_W         = 32,
  parameter int unsigned         INSTR_W      = 32,
  parameter logic [INSTR_W-1:0]  BUBBLE_INSTR = '0
`ifdef PSR_PERF_CNT_EN
  ,
  parameter int unsigned         CNT_W        = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef PSR_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  logic               main_valid_q, main_valid_d;
  logic               skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               in_ready_q, in_ready_d;
  logic               in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_pc_q    <= '0;
      skid_pc_q    <= '0;
      main_instr_q <= '0;
      skid_instr_q <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_pc_q    <= main_pc_d;
      skid_pc_q    <= skid_pc_d;
      main_instr_q <= main_instr_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= in_ready_d;
    end
  end

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_pc_d    = main_pc_q;
    skid_pc_d    = skid_pc_q;
    main_instr_d = main_instr_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      // A same-cycle out_fire has already been taken downstream; only held state is dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_pc_d    = '0;
      skid_pc_d    = '0;
      main_instr_d = '0;
      skid_instr_d = '0;
    end else if (skid_valid_q) begin
      if (out_fire) begin
        main_pc_d    = skid_pc_q;
        main_instr_d = skid_instr_q;
        skid_valid_d = 1'b0;
        skid_pc_d    = '0;
        skid_instr_d = '0;
      end
    end else if (main_valid_q) begin
      if (out_fire && in_fire) begin
        main_pc_d    = in_pc;
        main_instr_d = in_instr;
      end else if (out_fire) begin
        main_valid_d = 1'b0;
      end else if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = in_pc;
        skid_instr_d = in_instr;
      end
    end else if (in_fire) begin
      main_valid_d = 1'b1;
      main_pc_d    = in_pc;
      main_instr_d = in_instr;
    end
    // Registered ready: derived from next skid state, never from out_ready combinationally.
    in_ready_d = ~skid_valid_d;
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = main_valid_q;
    out_pc    = main_valid_q ? main_pc_q : '0;
    out_instr = main_valid_q ? main_instr_q : BUBBLE_INSTR;
  end

`ifdef PSR_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: driver queues expected PC/instr, negedge monitor checks.
module tb_pipe_stage_skid_reg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] BUBBLE = 32'h0000_0013;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
`ifdef PSR_PERF_CNT_EN
  logic [3:0]         stall_cnt;
  logic [3:0]         flush_cnt;
`endif

  pipe_stage_skid_reg #(
    .PC_W        (PC_W),
    .INSTR_W     (INSTR_W),
    .BUBBLE_INSTR(BUBBLE)
`ifdef PSR_PERF_CNT_EN
    ,
    .CNT_W       (4)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_instr(out_instr)
`ifdef PSR_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop on every output transfer; also check bubble encoding and hold-under-stall.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_word  = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && prev_stall) chk("hold", {out_pc, out_instr}, prev_word);
      if (!out_valid) chk("bubble", {out_pc, out_instr}, {32'h0, BUBBLE});
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {out_pc, out_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("out_data", {out_pc, out_instr}, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_pc, out_instr};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one input for one cycle; it must be accepted (ready is known from the sequence).
  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    chk("push_ready", {63'b0, in_ready}, 64'd1);
    exp_q.push_back({pc, instr});
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, {63'b0, out_valid}, 64'd0);
    chk({name, "_ready"}, {63'b0, in_ready}, 64'd1);
    chk({name, "_word"}, {out_pc, out_instr}, {32'h0, BUBBLE});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    repeat (2) cyc();
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Streaming: one transfer per cycle, latency one.
    out_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'(4 * i);
      in_instr = 32'h11 + 32'(i);
      chk("stream_ready", {63'b0, in_ready}, 64'd1);
      exp_q.push_back({32'(4 * i), 32'h11 + 32'(i)});
      cyc();
      chk("stream_lat", {out_valid, 31'b0, out_pc}, {1'b1, 31'b0, 32'(4 * i)});
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_count", 64'(n_out - n0), 64'd4);

    // Back-pressure into the skid entry, then release.
    out_ready = 1'b0;
    push(32'h100, 32'hAA);
    push(32'h104, 32'hBB);
    chk("bp_full_ready", {63'b0, in_ready}, 64'd0);
    chk("bp_hold", {out_pc, out_instr}, {32'h100, 32'hAA});
    repeat (2) cyc();
    chk("bp_hold2", {out_pc, out_instr}, {32'h100, 32'hAA});
    out_ready = 1'b1;
    cyc();
    chk("bp_drain_ready", {63'b0, in_ready}, 64'd1);
    chk("bp_second", {out_pc, out_instr}, {32'h104, 32'hBB});
    cyc();
    chk("bp_empty", {63'b0, out_valid}, 64'd0);

    // Flush while FULL with an offered input.
    out_ready = 1'b0;
    push(32'h300, 32'hCC);
    push(32'h304, 32'hDD);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'hEE;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk_idle("flush_full");
    out_ready = 1'b1;
    repeat (3) cyc();

    // Flush with same-cycle out_fire and in_fire.
    out_ready = 1'b0;
    push(32'h400, 32'h41);
    out_ready = 1'b1;
    n0 = n_out;
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h404; in_instr = 32'h42;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush_consumed", 64'(n_out - n0), 64'd1);
    chk_idle("flush_fire");
    repeat (3) cyc();

    // Asynchronous reset mid-cycle while FULL.
    out_ready = 1'b0;
    push(32'h500, 32'h51);
    push(32'h504, 32'h52);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cyc();

`ifdef PSR_PERF_CNT_EN
    chk("cnt_rst", {56'b0, stall_cnt, flush_cnt}, 64'h00);
    for (int i = 0; i < 3; i++) begin
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();
    end
    chk("cnt_flush3", {56'b0, stall_cnt, flush_cnt}, 64'h03);
    push(32'h600, 32'h61);
    repeat (5) cyc();
    chk("cnt_stall5", {56'b0, stall_cnt, flush_cnt}, 64'h53);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    exp_q.delete();
    cyc();
    chk("cnt_after_flush", {56'b0, stall_cnt, flush_cnt}, 64'h64);
    push(32'h700, 32'h71);
    repeat (20) cyc();
    chk("cnt_sat", {56'b0, stall_cnt, flush_cnt}, 64'hF4);
    out_ready = 1'b1;
    repeat (2) cyc();
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
